// File: rtl/fifo_cmd_reader.sv
// fifo_cmd_reader
//   Pops command packets from a BRAM-backed FIFO (one-cycle read latency)
//   and turns them into VRAM writes.
//   Packet: header {opcode[15:12], count[11:0]} followed by operands.
//     0x1 WRITE : addr, data            -> one write
//     0x2 BURST : addr, count x data    -> data[i] to addr+i
//     0x3 FILL  : addr, data            -> data to addr..addr+count-1
//     0x0 NOP   : header only           -> pkt_done
//     other     : header only           -> cmd_err + pkt_done
// Ports
//   clk, rst_n        clock, async active-low reset
//   fifo_data/empty/valid, fifo_read_en   FIFO read side
//   vram_addr/data/we, vram_busy          VRAM write side
//   busy, pkt_done, cmd_err               status
module fifo_cmd_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  input  logic              fifo_valid,
  output logic              fifo_read_en,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_data,
  output logic              vram_we,
  input  logic              vram_busy,
  output logic              busy,
  output logic              pkt_done,
  output logic              cmd_err
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_ADDR, S_DATA, S_WRITE} state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_BURST = 4'h2;
  localparam logic [3:0] OP_FILL  = 4'h3;

  state_t            r_state;
  logic [3:0]        r_op;
  logic [11:0]       r_cnt;    // writes remaining, including the one in flight
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_we;
  logic              r_pend;   // pop issued, word not yet returned
  logic              r_pkt_done;
  logic              r_cmd_err;

  logic w_need, w_rd, w_cap;

  // States that consume a word: IDLE (header), ADDR, DATA. HDR only waits
  // for the header already popped from IDLE.
  assign w_need = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
  // rst_n in the gate keeps the pop request low while reset is held, even
  // with a non-empty FIFO sitting in IDLE.
  assign w_rd   = rst_n && w_need && !r_pend && !fifo_empty && !vram_busy;
  // Words returned with no pop outstanding (e.g. across a reset) are dropped.
  assign w_cap  = fifo_valid && r_pend;

  assign fifo_read_en = w_rd;
  assign vram_addr    = r_addr;
  assign vram_data    = r_data;
  assign vram_we      = r_we;
  assign busy         = (r_state != S_IDLE);
  assign pkt_done     = r_pkt_done;
  assign cmd_err      = r_cmd_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= OP_NOP;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_we       <= 1'b0;
      r_pend     <= 1'b0;
      r_pkt_done <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      r_cmd_err  <= 1'b0;

      if (w_rd)            r_pend <= 1'b1;
      else if (fifo_valid) r_pend <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_rd) r_state <= S_HDR;
        end

        S_HDR: begin
          if (w_cap) begin
            r_op  <= fifo_data[15:12];
            r_cnt <= fifo_data[11:0];
            case (fifo_data[15:12])
              OP_WRITE: begin
                r_cnt   <= 12'd1;   // count field is ignored for WRITE
                r_state <= S_ADDR;
              end
              OP_BURST, OP_FILL: r_state <= S_ADDR;
              OP_NOP: begin
                r_pkt_done <= 1'b1;
                r_state    <= S_IDLE;
              end
              default: begin
                r_pkt_done <= 1'b1;
                r_cmd_err  <= 1'b1;
                r_state    <= S_IDLE;
              end
            endcase
          end
        end

        S_ADDR: begin
          if (w_cap) begin
            r_addr <= fifo_data[ADDR_W-1:0];
            // Empty BURST has no data words to consume.
            if (r_op == OP_BURST && r_cnt == 12'd0) begin
              r_pkt_done <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_cap) begin
            r_data <= fifo_data;
            // Empty FILL still consumes its data word, then writes nothing.
            if (r_op == OP_FILL && r_cnt == 12'd0) begin
              r_pkt_done <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_we    <= 1'b1;
              r_state <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          // Address/data/strobe simply hold while vram_busy is high.
          if (!vram_busy) begin
            if (r_op == OP_WRITE || r_cnt == 12'd1) begin
              r_we       <= 1'b0;
              r_cnt      <= '0;
              r_pkt_done <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_cnt  <= r_cnt - 12'd1;
              r_addr <= r_addr + ADDR_W'(1);   // wraps modulo 2^ADDR_W
              if (r_op == OP_BURST) begin
                r_we    <= 1'b0;
                r_state <= S_DATA;
              end
              // FILL keeps the strobe up: one write per clock.
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_cmd_reader.sv
// Directed bench for fifo_cmd_reader: a small BRAM-style FIFO model
// (data/valid one cycle after the pop), a VRAM write logger and pulse
// counters; expected values are hand-computed from the packet formats.
module tb_fifo_cmd_reader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_valid;
  logic        fifo_read_en;
  logic [15:0] vram_addr;
  logic [15:0] vram_data;
  logic        vram_we;
  logic        vram_busy;
  logic        busy;
  logic        pkt_done;
  logic        cmd_err;

  always #5 clk = ~clk;

  fifo_cmd_reader #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
    .fifo_read_en(fifo_read_en),
    .vram_addr(vram_addr), .vram_data(vram_data), .vram_we(vram_we),
    .vram_busy(vram_busy),
    .busy(busy), .pkt_done(pkt_done), .cmd_err(cmd_err)
  );

  // FIFO model
  logic [15:0] mem [0:63];
  logic [5:0]  wp = '0;
  logic [5:0]  rp = '0;
  logic        inj = 1'b0;   // spurious valid injection
  assign fifo_empty = (rp == wp);

  initial begin
    fifo_data  = '0;
    fifo_valid = 1'b0;
  end

  always @(posedge clk) begin
    fifo_valid <= fifo_read_en || inj;
    if (fifo_read_en) begin
      fifo_data <= mem[rp];
      rp        <= rp + 6'd1;
    end
    if (!rst_n) rp <= wp;   // FIFO is flushed while reset is held
  end

  // Monitors
  logic [31:0] wlog[$];
  int pkt_cnt = 0, err_cnt = 0, bad_rd = 0;
  always @(posedge clk) begin
    if (vram_we && !vram_busy && rst_n) wlog.push_back({vram_addr, vram_data});
    if (pkt_done) pkt_cnt++;
    if (cmd_err)  err_cnt++;
    if (fifo_read_en && fifo_empty) bad_rd++;
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    mem[wp] = w;
    wp = wp + 6'd1;
  endtask

  task automatic wait_pkts(input int target);
    for (int i = 0; i < 300 && pkt_cnt < target; i++) @(negedge clk);
    chk("pkt_wait", pkt_cnt, target);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [15:0] a, input logic [15:0] d);
    if (idx < wlog.size()) chk(tag, wlog[idx], {a, d});
    else                   chk(tag, 32'hDEAD_DEAD, {a, d});
  endtask

  initial begin
    rst_n = 1'b0;
    vram_busy = 1'b0;
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_rd_en", fifo_read_en, 0);
    chk("rst_we",    vram_we, 0);
    chk("rst_addr",  vram_addr, 0);
    chk("rst_data",  vram_data, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  pkt_done, 0);
    chk("rst_err",   cmd_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single WRITE
    wlog.delete();
    push(16'h1000); push(16'h0040); push(16'hA455);
    wait_pkts(1);
    chk("wr_n",   wlog.size(), 1);
    chk_wr("wr_0", 0, 16'h0040, 16'hA455);
    chk("wr_err", err_cnt, 0);
    chk("wr_idle", busy, 0);

    // BURST across address wrap
    wlog.delete();
    push(16'h2003); push(16'hFFFE); push(16'h1111); push(16'h2222); push(16'h3333);
    wait_pkts(2);
    chk("bu_n", wlog.size(), 3);
    chk_wr("bu_0", 0, 16'hFFFE, 16'h1111);
    chk_wr("bu_1", 1, 16'hFFFF, 16'h2222);
    chk_wr("bu_2", 2, 16'h0000, 16'h3333);

    // FILL with a 3-cycle stall on the second write
    wlog.delete();
    push(16'h3004); push(16'h0100); push(16'hFFFF);
    for (int i = 0; i < 100 && wlog.size() < 1; i++) @(negedge clk);
    vram_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st_addr", vram_addr, 16'h0101);
      chk("st_data", vram_data, 16'hFFFF);
      chk("st_we",   vram_we, 1);
      chk("st_rd",   fifo_read_en, 0);
    end
    vram_busy = 1'b0;
    wait_pkts(3);
    chk("fi_n", wlog.size(), 4);
    chk_wr("fi_0", 0, 16'h0100, 16'hFFFF);
    chk_wr("fi_1", 1, 16'h0101, 16'hFFFF);
    chk_wr("fi_2", 2, 16'h0102, 16'hFFFF);
    chk_wr("fi_3", 3, 16'h0103, 16'hFFFF);

    // unknown opcode then WRITE
    wlog.delete();
    push(16'h7000); push(16'h1000); push(16'h0010); push(16'h115C);
    wait_pkts(5);
    chk("uk_err", err_cnt, 1);
    chk("uk_n",   wlog.size(), 1);
    chk_wr("uk_0", 0, 16'h0010, 16'h115C);

    // zero-count BURST / FILL: operands consumed, no writes
    wlog.delete();
    push(16'h2000); push(16'h0200);
    push(16'h3000); push(16'h0300); push(16'h4444);
    push(16'h0000);
    wait_pkts(8);
    chk("z_n", wlog.size(), 0);
    chk("z_empty", fifo_empty, 1);

    // FIFO runs dry mid-BURST
    wlog.delete();
    bad_rd = 0;
    push(16'h2002); push(16'h0500);
    repeat (14) @(negedge clk);
    chk("dry_busy", busy, 1);
    chk("dry_n",    wlog.size(), 0);
    chk("dry_rd",   bad_rd, 0);
    push(16'hAAAA); push(16'hBBBB);
    wait_pkts(9);
    chk("dry_w_n", wlog.size(), 2);
    chk_wr("dry_0", 0, 16'h0500, 16'hAAAA);
    chk_wr("dry_1", 1, 16'h0501, 16'hBBBB);

    // reset mid-BURST
    wlog.delete();
    push(16'h2004); push(16'h0200); push(16'h0001); push(16'h0002);
    push(16'h0003); push(16'h0004);
    for (int i = 0; i < 100 && wlog.size() < 1; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_we",   vram_we, 0);
    chk("mr_addr", vram_addr, 0);
    chk("mr_data", vram_data, 0);
    chk("mr_busy", busy, 0);
    chk("mr_rd",   fifo_read_en, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    // stray valid with no pop outstanding
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr_stray_busy", busy, 0);
    chk("mr_pkts", pkt_cnt, 9);
    wlog.delete();
    push(16'h1000); push(16'h0033); push(16'h5A5A);
    wait_pkts(10);
    chk("mr_n", wlog.size(), 1);
    chk_wr("mr_0", 0, 16'h0033, 16'h5A5A);
    chk("tot_err", err_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
